// File: rtl/dps_irq_arbiter.sv
// rtl/dps_irq_arbiter.sv - four-source round-robin interrupt arbiter with mask and device ack pulse
module dps_irq_arbiter (
  input  logic       iCLOCK,
  input  logic       inRESET,
  input  logic [3:0] iDEV_IRQ,
  output logic [3:0] oDEV_ACK,
  input  logic       iMASK_VALID,
  input  logic [3:0] iMASK_DATA,
  output logic [3:0] oMASK,
  output logic       oIRQ_VALID,
  output logic [1:0] oIRQ_NUM,
  input  logic       iIRQ_ACK
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] b_num;
  logic [1:0] b_rr_ptr;
  logic [3:0] b_mask;
  logic [3:0] eff_req;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;

  assign eff_req = iDEV_IRQ & b_mask;

  // Scan upward from the round-robin pointer, wrapping naturally in 2 bits.
  always_comb begin
    winner = b_rr_ptr;
    found  = 1'b0;
    idx    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = b_rr_ptr + 2'(i);
      if (!found && eff_req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = REQ;
      REQ:     if (iIRQ_ACK) state_next = ACK;
      ACK:     state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      b_num    <= 2'd0;
      b_rr_ptr <= 2'd0;
      b_mask   <= 4'hF;
    end else begin
      if (state == IDLE && found) begin
        b_num <= winner;
      end
      if (state == ACK) begin
        b_rr_ptr <= b_num + 2'd1;
      end
      if (iMASK_VALID) begin
        b_mask <= iMASK_DATA;
      end
    end
  end

  always_comb begin
    oIRQ_VALID = (state == REQ);
    oIRQ_NUM   = b_num;
    oMASK      = b_mask;
    oDEV_ACK   = (state == ACK) ? (4'b0001 << b_num) : 4'b0000;
  end

endmodule
